// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the synchronous instruction
// memory and buffers fetched words in a 2-entry FIFO handed to decode by valid/ready.

module inst_fetch_unit_chk #(
  parameter int ADDR_W    = 32,
  parameter int PROG_SIZE = 108
) (
  input logic       clk,
  input logic       reset,
  input logic       imem_req,
  input logic [1:0] imem_addr_lo,
  input logic [1:0] fifo_count
);
  localparam logic [63:0] PC_SPACE = 64'd1 << ADDR_W;

  // Parameter legality and structural invariants of the fetch unit
  always @(posedge clk) begin
    if (!reset) begin
      assert (64'(PROG_SIZE) + 64'd4 < PC_SPACE);
      assert (!imem_req || (imem_addr_lo == 2'b00));
      assert (fifo_count <= 2'd2);
    end
  end
endmodule

module inst_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int PROG_SIZE  = 108,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PROG_END = ADDR_W'(PROG_SIZE);
  localparam logic [2:0]        DEPTH    = 3'(FIFO_DEPTH);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_pc_r;
  logic              armed_r;
  logic              inflight_r;
  logic              halted_r;
  logic [CNT_W-1:0]  fetch_count_r;
  logic [1:0]        count_r;
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [31:0]       data_r [2];
  logic [ADDR_W-1:0] ipc_r  [2];

  logic       redir_s;
  logic       pop_s;
  logic       push_s;
  logic       issue_s;
  logic [2:0] occ_s;

  // Per-cycle handshake and credit decode; armed_r keeps the bus quiet in the first cycle after reset
  always_comb begin
    redir_s = redirect_valid && (state_r != ST_DONE);
    pop_s   = (count_r != 2'd0) && inst_ready;
    push_s  = inflight_r && !redir_s;
    occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s = armed_r && (state_r == ST_RUN) && !redir_s &&
              (pc_r < PROG_END) && (occ_s < DEPTH);
  end

  // Next-state logic for RUN / DRAIN / DONE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (redir_s) state_s = ST_RUN;
        else if (pc_r >= PROG_END) state_s = ST_DRAIN;
        else state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (redir_s) state_s = ST_RUN;
        else if ((count_r == 2'd0) && !inflight_r) state_s = ST_DONE;
        else state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_DONE;
      default: state_s = ST_RUN;
    endcase
  end

  // State, PC, outstanding-request tracking and retired-fetch counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      pc_r          <= {ADDR_W{1'b0}};
      req_pc_r      <= {ADDR_W{1'b0}};
      armed_r       <= 1'b0;
      inflight_r    <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      halted_r   <= (state_s == ST_DONE);
      armed_r    <= 1'b1;
      inflight_r <= issue_s;
      if (redir_s) begin
        pc_r <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (issue_s) begin
        pc_r     <= pc_r + ADDR_W'(4);
        req_pc_r <= pc_r;
      end
      if (pop_s) fetch_count_r <= fetch_count_r + CNT_W'(1);
    end
  end

  // Output FIFO; a redirect discards everything not accepted this cycle, including the arriving response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_r[i] <= 32'd0;
        ipc_r[i]  <= {ADDR_W{1'b0}};
      end
    end else if (redir_s) begin
      count_r  <= 2'd0;
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        data_r[wr_ptr_r] <= imem_rdata;
        ipc_r[wr_ptr_r]  <= req_pc_r;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  assign imem_req    = issue_s;
  assign imem_addr   = pc_r;
  assign inst_valid  = (count_r != 2'd0);
  assign inst_data   = data_r[rd_ptr_r];
  assign inst_pc     = ipc_r[rd_ptr_r];
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

  inst_fetch_unit_chk #(
    .ADDR_W    (ADDR_W),
    .PROG_SIZE (PROG_SIZE)
  ) u_chk (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr_lo (imem_addr[1:0]),
    .fifo_count   (count_r)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized
// ready/redirect traffic checked against an in-order program-stream model.

module tb_inst_fetch_unit;
  localparam logic [31:0] PEND = 32'd108;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;
  logic [15:0] fetch_count;
  logic [31:0] mem [64];
  int n_tests = 0;
  int n_fail = 0;

  inst_fetch_unit #(.ADDR_W(32), .PROG_SIZE(108), .FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .halted(halted), .fetch_count(fetch_count));

  always #5 clk = ~clk;

  // synchronous instruction memory: data one cycle after the request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[7:2]];
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 64; i++) mem[i] = rnd ? $urandom : i;
  endtask

  task automatic apply_reset();
    reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // set inputs for one cycle at the falling edge, then settle before sampling
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] tgt);
    @(negedge clk);
    inst_ready = rdy; redirect_valid = rv; redirect_pc = tgt;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; #2; reset = 1'b1; #3;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    n_tests++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    n_tests++; if (inst_data !== 32'd0 || inst_pc !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got data=%h pc=%h want 0/0", inst_data, inst_pc); end
    n_tests++; if (halted !== 1'b0 || fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_status: got halted=%b count=%0d want 0/0", halted, fetch_count); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [31:0] exp_pc;
    int acc_n, req_n, halt_c, first_c, last_c;
    exp_pc = 32'd0; acc_n = 0; req_n = 0; halt_c = 0; first_c = 0; last_c = 0;
    fill_mem(1'b0);
    apply_reset();
    for (int c = 1; c <= 40; c++) begin
      drive(1'b1, 1'b0, 32'd0);
      if (imem_req) req_n++;
      if (halted && halt_c == 0) halt_c = c;
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (inst_pc !== exp_pc || inst_data !== (exp_pc >> 2)) begin
          n_fail++; $display("FAIL straight_stream: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp_pc, exp_pc >> 2);
        end
        if (acc_n == 0) first_c = c;
        last_c = c; acc_n++; exp_pc += 32'd4;
      end
    end
    n_tests++; if (acc_n != 27) begin n_fail++; $display("FAIL straight_count: got %0d deliveries want 27", acc_n); end
    n_tests++; if (last_c - first_c != 26) begin n_fail++; $display("FAIL straight_gapless: got span %0d want 26", last_c - first_c); end
    n_tests++; if (req_n > 27) begin n_fail++; $display("FAIL straight_reqs: got %0d requests want <=27", req_n); end
    n_tests++; if (fetch_count !== 16'd27) begin n_fail++; $display("FAIL straight_fetch_count: got %0d want 27", fetch_count); end
    n_tests++; if (halt_c == 0 || halt_c > 31) begin n_fail++; $display("FAIL straight_halt_cycle: got %0d want 1..31", halt_c); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    fill_mem(1'b1);
    apply_reset();
    for (int c = 0; c < 10 && !inst_valid; c++) drive(1'b0, 1'b0, 32'd0);
    n_tests++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", inst_valid); end
    d0 = mem[0];
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 32'd0);
      n_tests++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_data !== d0 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: got v=%b pc=%h data=%h req=%b want 1/0/%h/0", inst_valid, inst_pc, inst_data, imem_req, d0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'd0);
      n_tests++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_data !== mem[k]) begin
        n_fail++; $display("FAIL bp_release: got v=%b pc=%h data=%h want 1/%h/%h", inst_valid, inst_pc, inst_data, 32'(4 * k), mem[k]);
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    logic pend, fired, chk_issue, seen10;
    int acc_n;
    exp_pc = 32'd0; pend = 1'b0; fired = 1'b0; chk_issue = 1'b0; seen10 = 1'b0; acc_n = 0;
    fill_mem(1'b1);
    apply_reset();
    for (int c = 0; c < 200 && !halted; c++) begin
      drive(1'b1, pend, 32'h40);
      if (chk_issue) begin
        n_tests++; chk_issue = 1'b0;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_target_issue: got req=%b addr=%h want 1/40", imem_req, imem_addr); end
      end
      if (inst_valid) begin
        n_tests++;
        if (inst_pc == 32'h10 && fired) seen10 = 1'b1;
        if (inst_pc !== exp_pc || inst_data !== mem[exp_pc[7:2]]) begin
          n_fail++; $display("FAIL redir_stream: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp_pc, mem[exp_pc[7:2]]);
        end
        exp_pc += 32'd4; acc_n++;
      end
      if (pend) begin
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: got req=%b want 0", imem_req); end
        exp_pc = 32'h40; pend = 1'b0; fired = 1'b1; chk_issue = 1'b1;
      end else if (!fired && imem_req && imem_addr == 32'h10) begin
        pend = 1'b1;
      end
    end
    n_tests++; if (!fired || seen10) begin n_fail++; $display("FAIL redir_flush: got fired=%b seen10=%b want 1/0", fired, seen10); end
    n_tests++; if (halted !== 1'b1 || fetch_count !== 16'(acc_n) || acc_n != 15) begin
      n_fail++; $display("FAIL redir_count: got halted=%b count=%0d delivered=%0d want 1/15/15", halted, fetch_count, acc_n);
    end
  endtask

  task automatic test_redirect_beyond();
    int acc_n;
    logic any_valid, any_req;
    acc_n = 0; any_valid = 1'b0; any_req = 1'b0;
    fill_mem(1'b1);
    apply_reset();
    for (int c = 0; c < 20 && acc_n < 5; c++) begin
      drive(1'b1, 1'b0, 32'd0);
      if (inst_valid) acc_n++;
    end
    drive(1'b1, 1'b1, 32'h6E);
    if (inst_valid) acc_n++;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, 32'd0);
      any_valid |= inst_valid; any_req |= imem_req;
    end
    n_tests++; if (any_valid || any_req) begin n_fail++; $display("FAIL beyond_quiet: got valid=%b req=%b want 0/0", any_valid, any_req); end
    n_tests++; if (halted !== 1'b1 || fetch_count !== 16'(acc_n)) begin
      n_fail++; $display("FAIL beyond_halt: got halted=%b count=%0d want 1/%0d", halted, fetch_count, acc_n);
    end
    drive(1'b1, 1'b1, 32'd0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 32'd0);
      n_tests++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL done_ignores_redirect: got halted=%b req=%b valid=%b want 1/0/0", halted, imem_req, inst_valid);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] exp_pc;
    int acc_n;
    fill_mem(1'b1);
    apply_reset();
    for (int c = 0; c < 6; c++) drive(1'b1, 1'b0, 32'd0);
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 32'd0);
    n_tests++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || fetch_count == 16'd0) begin
      n_fail++; $display("FAIL midrun_setup: got valid=%b req=%b count=%0d want 1/0/nonzero", inst_valid, imem_req, fetch_count);
    end
    #2; reset = 1'b1; #1;
    n_tests++;
    if ({imem_req, imem_addr, inst_valid, inst_data, inst_pc, halted, fetch_count} !== 116'd0) begin
      n_fail++; $display("FAIL midrun_async_reset: got req=%b addr=%h v=%b data=%h pc=%h h=%b cnt=%0d want all 0",
                         imem_req, imem_addr, inst_valid, inst_data, inst_pc, halted, fetch_count);
    end
    @(negedge clk); reset = 1'b0;
    exp_pc = 32'd0; acc_n = 0;
    for (int c = 0; c < 12 && acc_n < 3; c++) begin
      drive(1'b1, 1'b0, 32'd0);
      if (inst_valid) begin
        n_tests++;
        if (inst_pc !== exp_pc || inst_data !== mem[exp_pc[7:2]]) begin
          n_fail++; $display("FAIL midrun_restart: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp_pc, mem[exp_pc[7:2]]);
        end
        exp_pc += 32'd4; acc_n++;
      end
    end
    n_tests++; if (acc_n != 3) begin n_fail++; $display("FAIL midrun_restart_timeout: got %0d deliveries want 3", acc_n); end
  endtask

  task automatic test_redirect_accept();
    fill_mem(1'b1);
    apply_reset();
    for (int c = 0; c < 10 && !inst_valid; c++) drive(1'b0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 32'd0);
    n_tests++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL ra_full: got valid=%b req=%b want 1/0", inst_valid, imem_req); end
    drive(1'b1, 1'b1, 32'h20);
    n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'd0) begin n_fail++; $display("FAIL ra_head: got valid=%b pc=%h want 1/0", inst_valid, inst_pc); end
    drive(1'b1, 1'b0, 32'd0);
    n_tests++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL ra_count: got %0d want 1", fetch_count); end
    n_tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL ra_flush_issue: got valid=%b req=%b addr=%h want 0/1/20", inst_valid, imem_req, imem_addr);
    end
    for (int c = 0; c < 5 && !inst_valid; c++) drive(1'b1, 1'b0, 32'd0);
    n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst_data !== mem[8] || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL ra_target: got v=%b pc=%h data=%h cnt=%0d want 1/20/%h/1", inst_valid, inst_pc, inst_data, fetch_count, mem[8]);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, start, tgt, want_end;
    logic rdy, rv;
    int acc_n, n_redir;
    exp_pc = 32'd0; start = 32'd0; acc_n = 0; n_redir = 0;
    fill_mem(1'b1);
    apply_reset();
    for (int c = 0; c < 3000 && !halted; c++) begin
      rdy = ($urandom_range(9, 0) < 7);
      rv  = (n_redir < 5) && ($urandom_range(29, 0) == 0);
      tgt = $urandom_range(127, 0);
      drive(rdy, rv, tgt);
      if (inst_valid && inst_ready) begin
        n_tests++;
        if (inst_pc !== exp_pc || inst_data !== mem[exp_pc[7:2]]) begin
          n_fail++; $display("FAIL random_stream: got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp_pc, mem[exp_pc[7:2]]);
        end
        exp_pc += 32'd4; acc_n++;
      end
      if (rv && !halted) begin
        exp_pc = tgt & 32'hFFFF_FFFC; start = exp_pc; n_redir++;
      end
    end
    want_end = (start >= PEND) ? start : PEND;
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL random_halt: got %b want 1", halted); end
    n_tests++; if (fetch_count !== 16'(acc_n)) begin n_fail++; $display("FAIL random_count: got %0d want %0d", fetch_count, acc_n); end
    n_tests++; if (exp_pc !== want_end) begin n_fail++; $display("FAIL random_complete: got end pc %h want %h", exp_pc, want_end); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_redirect_beyond();
    test_reset_midrun();
    test_redirect_accept();
    for (int r = 0; r < 4; r++) test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
